// File: rtl/comm_pkg.sv
// Shared types and defaults for the UART command link between the host and the LA_dig core.
package comm_pkg;

    localparam int unsigned DEFAULT_BAUD_DIV = 868;
    localparam int unsigned DEFAULT_TIMEOUT  = 20000;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10
    } opcode_t;

    typedef struct packed {
        opcode_t    opcode;
        logic [5:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef enum logic {
        WAIT_HI,
        WAIT_LO
    } rx_asm_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RXB_IDLE,
        RXB_START,
        RXB_DATA,
        RXB_STOP
    } rx_bit_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM and LSB-first shift register.
module uart_rx
    import comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_err,
    output logic       rx_busy
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam int unsigned HALF  = BAUD_DIV / 2;

    rx_bit_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             rx_s1_q, rx_s1_d;
    logic             rx_s2_q, rx_s2_d;
    logic             rx_prev_q, rx_prev_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RXB_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            rx_s1_q   <= rx_s1_d;
            rx_s2_q   <= rx_s2_d;
            rx_prev_q <= rx_prev_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        rx_s1_d   = rx;
        rx_s2_d   = rx_s1_q;
        rx_prev_d = rx_s2_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            RXB_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    state_d = RXB_START;
                    cnt_d   = '0;
                end
            end
            // Half a bit in: a high line here means a glitch, not a start bit.
            RXB_START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_s2_q ? RXB_IDLE : RXB_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RXB_DATA: begin
                if (cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    cnt_d = '0;
                    sh_d  = {rx_s2_q, sh_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RXB_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RXB_STOP: begin
                if (cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = RXB_IDLE;
                    done_d  = rx_s2_q;
                    err_d   = !rx_s2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RXB_IDLE;
        endcase

        busy_d = (state_d != RXB_IDLE);
    end

    assign rx_data = sh_q;
    assign rx_done = done_q;
    assign rx_err  = err_q;
    assign rx_busy = busy_q;

endmodule

// File: rtl/uart_cmd_responder.sv
// Device side of the host command link: assembles 16-bit commands from UART bytes
// and serialises 8-bit responses back to the host.
module uart_cmd_responder
    import comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy,
    output logic        frm_err
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_err;
    logic       rx_busy;

    uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx      (RX),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .rx_err  (rx_err),
        .rx_busy (rx_busy)
    );

    rx_asm_state_t   asm_q, asm_d;
    logic [7:0]      hi_q, hi_d;
    cmd_t            cmd_q, cmd_d;
    logic            rdy_q, rdy_d;
    logic [TO_W-1:0] to_q, to_d;

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             sent_q, sent_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q      <= WAIT_HI;
            hi_q       <= '0;
            cmd_q      <= '0;
            rdy_q      <= 1'b0;
            to_q       <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            sent_q     <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            hi_q       <= hi_d;
            cmd_q      <= cmd_d;
            rdy_q      <= rdy_d;
            to_q       <= to_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            sent_q     <= sent_d;
        end
    end

    // Command assembler; completion is applied after the clear so it wins a tie.
    always_comb begin
        asm_d = asm_q;
        hi_d  = hi_q;
        cmd_d = cmd_q;
        rdy_d = rdy_q;
        to_d  = to_q;

        if (clr_cmd_rdy) begin
            rdy_d = 1'b0;
        end

        if (rx_err) begin
            asm_d = WAIT_HI;
            hi_d  = '0;
        end else begin
            unique case (asm_q)
                WAIT_HI: begin
                    if (rx_done) begin
                        hi_d  = rx_data;
                        to_d  = '0;
                        asm_d = WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (rx_done) begin
                        cmd_d = cmd_t'({hi_q, rx_data});
                        rdy_d = 1'b1;
                        asm_d = WAIT_HI;
                    end else if (!rx_busy) begin
                        if (to_q == TO_W'(TIMEOUT)) begin
                            hi_d  = '0;
                            asm_d = WAIT_HI;
                        end else begin
                            to_d = to_q + TO_W'(1);
                        end
                    end
                end
                default: asm_d = WAIT_HI;
            endcase
        end
    end

    // Response transmitter; the stop bit's last cycle overlaps the resp_sent cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        sent_d     = 1'b0;

        unique case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (send_resp && !sent_q) begin
                    tx_sh_d    = resp;
                    tx_cnt_d   = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_sh_q[0];
                    tx_sh_d    = tx_sh_q >> 1;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_d     = tx_sh_q[0];
                        tx_sh_d  = tx_sh_q >> 1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_W'(BAUD_DIV - 2)) begin
                    tx_cnt_d   = '0;
                    busy_d     = 1'b0;
                    sent_d     = 1'b1;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign TX        = tx_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = rdy_q;
    assign resp_sent = sent_q;
    assign tx_busy   = busy_q;
    assign frm_err   = rx_err;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: command pair table plus hand-written TX/reset/error sequences.
module tb_uart_cmd_responder;

    localparam int unsigned BD = 16;
    localparam int unsigned TO = 400;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        tx;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic        tx_busy;
    logic        frm_err;

    uart_cmd_responder #(
        .BAUD_DIV (BD),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (rx),
        .TX          (tx),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .tx_busy     (tx_busy),
        .frm_err     (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int rdy_rises   = 0;
    int rise_cyc    = 0;
    int err_pulses  = 0;
    int sent_pulses = 0;
    logic rdy_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_rdy && !rdy_prev) begin
            rdy_rises = rdy_rises + 1;
            rise_cyc  = cyc;
        end
        rdy_prev = cmd_rdy;
        if (frm_err)   err_pulses  = err_pulses + 1;
        if (resp_sent) sent_pulses = sent_pulses + 1;
    end

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_cmd;
    } pair_vec_t;

    pair_vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec = n_vec + 1;
        if (act < lo || act > hi) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Host-side 8N1 frame, LSB first; start reports the cycle the start bit was driven.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int start);
        @(posedge clk);
        #1;
        start = cyc;
        rx = 1'b0;
        repeat (BD) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (BD) @(posedge clk);
        end
        #1 rx = stop_bit;
        repeat (BD) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    task automatic clear_rdy();
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b0;
    endtask

    logic [31:0] exp_tx;
    int s;
    int r0;
    int e0;
    int p0;
    logic [7:0] tx_byte;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{hi: 8'h41, lo: 8'hA5, exp_cmd: 16'h41A5};
        vecs[1] = '{hi: 8'h80, lo: 8'h00, exp_cmd: 16'h8000};
        vecs[2] = '{hi: 8'h7F, lo: 8'hFE, exp_cmd: 16'h7FFE};
        vecs[3] = '{hi: 8'h00, lo: 8'h00, exp_cmd: 16'h0000};
        vecs[4] = '{hi: 8'hBF, lo: 8'h5C, exp_cmd: 16'hBF5C};

        rst = 1'b1;
        rx = 1'b1;
        clr_cmd_rdy = 1'b0;
        resp = 8'h00;
        send_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_cmd", 32'(cmd), 32'h0);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        check("rst_resp_sent", 32'(resp_sent), 32'h0);
        check("rst_tx_busy", 32'(tx_busy), 32'h0);
        check("rst_frm_err", 32'(frm_err), 32'h0);

        // Command pair table
        for (int v = 0; v < 5; v++) begin
            clear_rdy();
            @(negedge clk);
            check("vec_rdy_cleared", 32'(cmd_rdy), 32'h0);
            r0 = rdy_rises;
            e0 = err_pulses;
            send_byte(vecs[v].hi, 1'b1, s);
            check("vec_no_rdy_after_hi", 32'(rdy_rises), 32'(r0));
            send_byte(vecs[v].lo, 1'b1, s);
            check("vec_one_rdy", 32'(rdy_rises), 32'(r0 + 1));
            check_range("vec_rdy_latency", rise_cyc - s, 153, 158);
            check("vec_cmd", 32'(cmd), 32'(vecs[v].exp_cmd));
            check("vec_no_frm_err", 32'(err_pulses), 32'(e0));
        end

        // Response frame 0xA5 with a second request ignored mid-frame
        p0 = sent_pulses;
        tx_byte = 8'hA5;
        @(posedge clk);
        for (int c = 0; c < 176; c++) begin
            #1;
            send_resp = (c == 0 || c == 50);
            resp = (c == 50) ? 8'h3C : 8'hA5;
            @(negedge clk);
            if (c >= 1 && c <= 16) exp_tx = 32'h0;
            else if (c >= 17 && c <= 144) exp_tx = 32'(tx_byte[(c - 17) / 16]);
            else exp_tx = 32'h1;
            check("tx_bit", 32'(tx), exp_tx);
            check("tx_resp_sent", 32'(resp_sent), 32'(c == 160));
            check("tx_busy", 32'(tx_busy), 32'(c >= 1 && c <= 159));
            @(posedge clk);
        end
        #1 send_resp = 1'b0;
        check("tx_one_sent", 32'(sent_pulses), 32'(p0 + 1));

        // High byte held just under the timeout still pairs
        clear_rdy();
        r0 = rdy_rises;
        send_byte(8'h5A, 1'b1, s);
        repeat (300) @(posedge clk);
        send_byte(8'h3C, 1'b1, s);
        check("short_gap_rdy", 32'(rdy_rises), 32'(r0 + 1));
        check("short_gap_cmd", 32'(cmd), 32'h5A3C);

        // Lone high byte times out and is dropped
        clear_rdy();
        r0 = rdy_rises;
        send_byte(8'h12, 1'b1, s);
        repeat (500) @(posedge clk);
        send_byte(8'h80, 1'b1, s);
        send_byte(8'h00, 1'b1, s);
        check("timeout_one_rdy", 32'(rdy_rises), 32'(r0 + 1));
        check("timeout_cmd", 32'(cmd), 32'h8000);

        // Framing error resynchronises the assembler
        clear_rdy();
        r0 = rdy_rises;
        e0 = err_pulses;
        send_byte(8'h33, 1'b1, s);
        send_byte(8'h55, 1'b0, s);
        check("frm_err_pulse", 32'(err_pulses), 32'(e0 + 1));
        check("frm_err_no_rdy", 32'(rdy_rises), 32'(r0));
        send_byte(8'h01, 1'b1, s);
        send_byte(8'h02, 1'b1, s);
        check("frm_err_resync_rdy", 32'(rdy_rises), 32'(r0 + 1));
        check("frm_err_resync_cmd", 32'(cmd), 32'h0102);

        // Clear held across completion: completion must win
        clear_rdy();
        r0 = rdy_rises;
        send_byte(8'hC0, 1'b1, s);
        #1 clr_cmd_rdy = 1'b1;
        fork
            send_byte(8'h33, 1'b1, s);
            begin
                for (int k = 0; k < 400; k++) begin
                    @(negedge clk);
                    if (cmd_rdy) break;
                end
                clr_cmd_rdy = 1'b0;
            end
        join
        @(negedge clk);
        check("clr_tie_rdy_rose", 32'(rdy_rises), 32'(r0 + 1));
        check("clr_tie_rdy_held", 32'(cmd_rdy), 32'h1);
        check("clr_tie_cmd", 32'(cmd), 32'hC033);

        // Reset in the middle of a response frame
        p0 = sent_pulses;
        @(posedge clk);
        for (int c = 0; c < 72; c++) begin
            #1;
            send_resp = (c == 0);
            resp = 8'h00;
            rst = (c == 70);
            @(negedge clk);
            if (c == 70) begin
                check("txrst_before_tx", 32'(tx), 32'h0);
                check("txrst_before_busy", 32'(tx_busy), 32'h1);
            end
            if (c == 71) begin
                check("txrst_tx", 32'(tx), 32'h1);
                check("txrst_busy", 32'(tx_busy), 32'h0);
                check("txrst_cmd_rdy", 32'(cmd_rdy), 32'h0);
            end
            @(posedge clk);
        end
        #1 rst = 1'b0;
        repeat (200) @(posedge clk);
        check("txrst_no_sent", 32'(sent_pulses), 32'(p0));

        // Reset midway through a byte drops the partial byte and the held high byte
        send_byte(8'h99, 1'b1, s);
        fork
            send_byte(8'hFF, 1'b1, s);
            begin
                repeat (80) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        @(negedge clk);
        check("rxrst_cmd", 32'(cmd), 32'h0);
        check("rxrst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        r0 = rdy_rises;
        send_byte(8'h00, 1'b1, s);
        check("rxrst_no_rdy_after_hi", 32'(rdy_rises), 32'(r0));
        send_byte(8'h05, 1'b1, s);
        check("rxrst_rdy", 32'(rdy_rises), 32'(r0 + 1));
        check("rxrst_cmd_after", 32'(cmd), 32'h0005);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Device-side end of the host command link: receives the 16-bit command sent by the host command master over UART, presents it to the logic-analyzer core, and transmits the core's 8-bit response back to the host. It sits between the board RX/TX pins and the LA_dig command processor. It is the counterpart of the host-side command master used in the bench.

## Interface
Parameters:
- BAUD_DIV, 868: clk cycles per UART bit (100 MHz clk, 115200 baud).
- TIMEOUT, 20000: maximum clk cycles allowed between the end of the high byte and the start bit of the low byte.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- RX  in  1  serial input from the host; asynchronous; idle high.
- TX  out  1  serial output to the host; idle high.
- cmd  out  16  last complete command. [15:14] opcode, [13:8] address, [7:0] data.
- cmd_rdy  out  1  level; a new command is held in cmd.
- clr_cmd_rdy  in  1  core acknowledges the command and clears cmd_rdy.
- resp  in  8  response byte, sampled on send_resp.
- send_resp  in  1  one-cycle request to transmit resp.
- resp_sent  out  1  one-cycle pulse when the stop bit of the response completes.
- tx_busy  out  1  high while a response frame is in progress.
- frm_err  out  1  one-cycle pulse when a received byte has a bad stop bit.

## Operation
- Framing is 8N1, LSB first, in both directions.
- RX receive path:
  - RX passes through a 2-flop synchronizer.
  - A falling edge while idle starts a byte. The input is sampled at BAUD_DIV/2; if it is high there, the start is false and the receiver returns to idle.
  - Data bits and the stop bit are then sampled every BAUD_DIV cycles, mid-bit.
  - Stop bit = 0: pulse frm_err, discard the byte, reset the command assembler to expect the high byte.
- Command assembler states: WAIT_HI, WAIT_LO.
  - WAIT_HI: a good byte is latched as the high byte; go to WAIT_LO and start the timeout counter.
  - WAIT_LO: a good byte updates cmd = {hi, byte} and sets cmd_rdy; go to WAIT_HI.
  - If TIMEOUT cycles elapse in WAIT_LO before a start bit is detected, discard the high byte and return to WAIT_HI (resync).
- cmd_rdy rules:
  - Set on command completion; cleared by clr_cmd_rdy.
  - If completion and clr_cmd_rdy occur in the same cycle, completion wins and cmd_rdy stays 1.
  - A new command arriving while cmd_rdy=1 overwrites cmd, and cmd_rdy stays 1.
- TX states: IDLE, START, DATA, STOP.
  - send_resp in IDLE latches resp and sets tx_busy.
  - send_resp while tx_busy=1 is ignored.
- Opcodes: READ=2'b00, WRITE=2'b01, DUMP=2'b10. The block passes them through undecoded.

## Timing
- Reset values: TX=1, cmd=16'h0000, cmd_rdy=0, resp_sent=0, tx_busy=0, frm_err=0. Both FSMs go to IDLE/WAIT_HI; any partial byte and the held high byte are discarded.
- rst asserted mid-frame takes effect at the next clk edge: TX goes high and tx_busy goes low on that edge.
- RX latency: cmd_rdy rises 1 cycle after the mid-stop-bit sample of the low byte. The 2-cycle synchronizer delay is included in sample alignment.
- TX timing, with send_resp in cycle 0:
  - TX goes low (start bit) in cycle 1.
  - Each bit lasts exactly BAUD_DIV cycles.
  - The stop bit ends at cycle 10·BAUD_DIV. resp_sent pulses in that cycle, and tx_busy falls in the same cycle.
- The earliest accepted next send_resp is the cycle after tx_busy falls.
- RX and TX operate fully independently; full duplex is allowed.
- Counter widths: $clog2(BAUD_DIV) for the baud counters, $clog2(TIMEOUT+1) for the timeout counter. All counters saturate or reload; none wraps.

## Structure
- Package comm_pkg holds:
  - opcode enum (READ/WRITE/DUMP)
  - packed cmd_t struct {opcode, addr[5:0], data[7:0]}
  - rx_asm_state_t and tx_state_t enums
  - default BAUD_DIV constant
- Sub-module uart_rx is natural. It contains the synchronizer, the bit-sampling FSM and the byte shift register, and outputs rx_data[7:0], rx_done and rx_err pulses.
- The assembler, timeout counter and TX FSM live in the top module.

## Test plan
Use BAUD_DIV=16 and TIMEOUT=400 to shorten simulation.
- Bytes 0x41 then 0xA5 → cmd=16'h41A5 and cmd_rdy=1, one cycle after the second stop-bit sample; frm_err stays 0.
- send_resp with resp=8'hA5 → TX bit sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each bit 16 cycles; resp_sent pulses at cycle 160; tx_busy falls in the same cycle; a second send_resp at cycle 50 is ignored.
- Byte 0x12, then idle for 500 cycles, then 0x80, 0x00 → cmd=16'h8000 only; no command containing 0x12.
- Byte with stop bit 0 → frm_err pulse and no cmd_rdy; a following good pair 0x01, 0x02 → cmd=16'h0102.
- clr_cmd_rdy in the same cycle as completion of 0xC0, 0x33 → cmd_rdy remains 1 and cmd=16'hC033.
- rst pulsed at cycle 70 of a TX frame, and again midway through a high byte → TX=1 and tx_busy=0 on the next edge; a subsequent pair 0x00, 0x05 gives cmd=16'h0005.
